// File: rtl/sha256_mm_pkg.sv
// rtl/sha256_mm_pkg.sv - register map, bit indices and sequencer states for the queued SHA-256 slave
package sha256_mm_pkg;
    localparam int MSG_BASE    = 'h00;
    localparam int CTRL_ADDR   = 'h10;
    localparam int STATUS_ADDR = 'h11;
    localparam int IRQ_ADDR    = 'h12;
    localparam int DIGEST_BASE = 'h80;

    localparam int CTRL_LAST  = 0;
    localparam int CTRL_PUSH  = 1;
    localparam int CTRL_CLEAR = 2;

    localparam int ST_BUSY  = 0;
    localparam int ST_DV    = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_FULL  = 3;
    localparam int ST_OVF   = 4;
    localparam int ST_COUNT = 8;

    localparam int ENTRY_W = 513;

    typedef enum logic [1:0] {IDLE, START, RUN} seq_state_e;
endpackage

// File: rtl/sha256_mm_queue_slave_if.sv
// rtl/sha256_mm_queue_slave_if.sv - Avalon-MM style register bus with master/slave views
interface sha256_mm_queue_slave_if #(
    parameter int ADDR_W = 8
) ();
    logic              iChipSelect_n;
    logic              iWrite_n;
    logic              iRead_n;
    logic [ADDR_W-1:0] iAddress;
    logic [31:0]       iData;
    logic [31:0]       oData;

    modport slave  (input iChipSelect_n, iWrite_n, iRead_n, iAddress, iData, output oData);
    modport master (output iChipSelect_n, iWrite_n, iRead_n, iAddress, iData, input oData);
endinterface

// File: rtl/sha256_block_fifo.sv
// rtl/sha256_block_fifo.sv - synchronous FIFO of {last, block} entries with flush
module sha256_block_fifo
    import sha256_mm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             iClk,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // At full, a simultaneous pop frees the head slot that the push reuses.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge iClk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
            else if (!push_ok && pop_ok) count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/sha256_core.sv
// rtl/sha256_core.sv - iterative SHA-256 compression, one round per cycle, chains blocks until last
module sha256_core (
    input  logic         iClk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] block,
    input  logic         last,
    output logic         done,
    output logic [255:0] digest
);
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [31:0] h_q [8];
    logic [31:0] v_q [8];
    logic [31:0] v_next [8];
    logic [31:0] w_q [16];
    logic [31:0] w_new;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [5:0]  round_q;
    logic        busy_q;
    logic        last_q;
    logic        fresh_q;

    always_comb begin
        t1 = v_q[7] + (ror(v_q[4], 6) ^ ror(v_q[4], 11) ^ ror(v_q[4], 25))
           + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[round_q] + w_q[0];
        t2 = (ror(v_q[0], 2) ^ ror(v_q[0], 13) ^ ror(v_q[0], 22))
           + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new = (ror(w_q[14], 17) ^ ror(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
              + (ror(w_q[1], 7) ^ ror(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
        v_next[0] = t1 + t2;
        v_next[1] = v_q[0];
        v_next[2] = v_q[1];
        v_next[3] = v_q[2];
        v_next[4] = v_q[3] + t1;
        v_next[5] = v_q[4];
        v_next[6] = v_q[5];
        v_next[7] = v_q[6];
    end

    always_ff @(posedge iClk) begin
        if (!reset_n) begin
            done    <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            fresh_q <= 1'b1;
            round_q <= '0;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
                v_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A block following a last block opens a new message from the IV.
                for (int i = 0; i < 8; i++) begin
                    h_q[i] <= fresh_q ? IV[i] : h_q[i];
                    v_q[i] <= fresh_q ? IV[i] : h_q[i];
                end
                for (int i = 0; i < 16; i++) w_q[i] <= block[511-32*i -: 32];
                round_q <= '0;
                busy_q  <= 1'b1;
                last_q  <= last;
            end else if (busy_q) begin
                for (int i = 0; i < 8; i++) v_q[i] <= v_next[i];
                for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                w_q[15] <= w_new;
                round_q <= round_q + 6'd1;
                if (round_q == 6'd63) begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_next[i];
                    busy_q  <= 1'b0;
                    done    <= 1'b1;
                    fresh_q <= last_q;
                end
            end
        end
    end

    assign digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
endmodule

// File: rtl/sha256_mm_queue_slave.sv
// rtl/sha256_mm_queue_slave.sv - queued SHA-256 MM slave; SHA256_IRQ_EN adds the IRQ register and oIrq
module sha256_mm_queue_slave
    import sha256_mm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic iClk,
    input  logic iReset,
    sha256_mm_queue_slave_if.slave bus
`ifdef SHA256_IRQ_EN
    ,
    output logic oIrq
`endif
);
    logic               wr_en, rd_en;
    logic               is_msg, is_ctrl, is_status, is_digest, is_irq;
    logic               soft_clear, push_req, clear_all;
    logic [31:0]        staging [16];
    logic [511:0]       staging_flat;
    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               core_start, core_done, core_rst_n;
    logic [255:0]       core_digest;
    logic [31:0]        digest_w [8];
    logic               digest_valid_q, overflow_q, capture;
    logic [31:0]        status, rdata;
    seq_state_e         state_q, state_d;

    assign wr_en      = !bus.iChipSelect_n && !bus.iWrite_n;
    assign rd_en      = !bus.iChipSelect_n && !bus.iRead_n;
    assign is_msg     = bus.iAddress < ADDR_W'(MSG_BASE + 16);
    assign is_ctrl    = bus.iAddress == ADDR_W'(CTRL_ADDR);
    assign is_status  = bus.iAddress == ADDR_W'(STATUS_ADDR);
    assign is_irq     = bus.iAddress == ADDR_W'(IRQ_ADDR);
    assign is_digest  = bus.iAddress[ADDR_W-1:3] == (ADDR_W-3)'(DIGEST_BASE / 8);
    assign soft_clear = wr_en && is_ctrl && bus.iData[CTRL_CLEAR];
    assign push_req   = wr_en && is_ctrl && bus.iData[CTRL_PUSH] && !soft_clear;
    assign clear_all  = iReset || soft_clear;
    assign core_rst_n = ~(iReset | soft_clear);
    assign capture    = (state_q == RUN) && core_done && fifo_head[ENTRY_W-1] && !soft_clear;

    always_comb begin
        staging_flat = '0;
        for (int i = 0; i < 16; i++) staging_flat[511-32*i -: 32] = staging[i];
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            for (int i = 0; i < 16; i++) staging[i] <= '0;
        end else if (wr_en && is_msg) begin
            staging[bus.iAddress[3:0]] <= bus.iData;
        end
    end

    sha256_block_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W), .CNT_W(CNT_W)) u_fifo (
        .iClk  (iClk),
        .flush (clear_all),
        .push  (push_req),
        .pop   (fifo_pop),
        .wdata ({bus.iData[CTRL_LAST], staging_flat}),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    sha256_core u_core (
        .iClk    (iClk),
        .reset_n (core_rst_n),
        .start   (core_start),
        .block   (fifo_head[511:0]),
        .last    (fifo_head[ENTRY_W-1]),
        .done    (core_done),
        .digest  (core_digest)
    );

    always_ff @(posedge iClk) begin
        if (clear_all) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // The head entry is popped only on done so it drives the core for the whole RUN.
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE:  if (fifo_count != '0) state_d = START;
            START: begin
                core_start = 1'b1;
                state_d    = RUN;
            end
            RUN:   if (core_done) begin
                fifo_pop = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (clear_all) begin
            digest_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            if (iReset) for (int i = 0; i < 8; i++) digest_w[i] <= '0;
        end else begin
            if (push_req && fifo_full && !fifo_pop) overflow_q <= 1'b1;
            if (state_q == START) digest_valid_q <= 1'b0;
            if (capture) begin
                for (int i = 0; i < 8; i++) digest_w[i] <= core_digest[255-32*i -: 32];
                digest_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        status                     = '0;
        status[ST_BUSY]            = (state_q != IDLE) || (fifo_count != '0);
        status[ST_DV]              = digest_valid_q;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_FULL]            = fifo_full;
        status[ST_OVF]             = overflow_q;
        status[ST_COUNT +: CNT_W]  = fifo_count;
    end

`ifdef SHA256_IRQ_EN
    logic irq_enable_q, irq_pending_q;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            irq_enable_q  <= 1'b0;
            irq_pending_q <= 1'b0;
            oIrq          <= 1'b0;
        end else begin
            if (wr_en && is_irq) begin
                irq_enable_q <= bus.iData[0];
                if (bus.iData[1]) irq_pending_q <= 1'b0;
            end
            if (capture && !digest_valid_q) irq_pending_q <= 1'b1;
            oIrq <= irq_enable_q & irq_pending_q;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (is_msg)         rdata = staging[bus.iAddress[3:0]];
        else if (is_status) rdata = status;
        else if (is_digest) rdata = digest_w[bus.iAddress[2:0]];
`ifdef SHA256_IRQ_EN
        else if (is_irq)    rdata = {30'b0, irq_pending_q, irq_enable_q};
`endif
    end

    always_ff @(posedge iClk) begin
        if (iReset)     bus.oData <= '0;
        else if (rd_en) bus.oData <= rdata;
        else            bus.oData <= '0;
    end
endmodule

// File: tb/tb_sha256_mm_queue_slave.sv
// tb/tb_sha256_mm_queue_slave.sv - directed self-checking bench for the queued SHA-256 slave
module tb_sha256_mm_queue_slave;
    logic iClk = 1'b0;
    logic iReset;
    int   total = 0;
    int   bad   = 0;

    always #5 iClk = ~iClk;

    sha256_mm_queue_slave_if #(.ADDR_W(8)) bus_if ();
`ifdef SHA256_IRQ_EN
    logic oIrq;
`endif

    sha256_mm_queue_slave #(.FIFO_DEPTH(2), .ADDR_W(8)) dut (
        .iClk   (iClk),
        .iReset (iReset),
        .bus    (bus_if)
`ifdef SHA256_IRQ_EN
        ,
        .oIrq   (oIrq)
`endif
    );

    task automatic bus_idle();
        bus_if.iChipSelect_n = 1'b1;
        bus_if.iWrite_n      = 1'b1;
        bus_if.iRead_n       = 1'b1;
        bus_if.iAddress      = '0;
        bus_if.iData         = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge iClk);
        bus_if.iChipSelect_n = 1'b0;
        bus_if.iWrite_n      = 1'b0;
        bus_if.iAddress      = a;
        bus_if.iData         = d;
        @(negedge iClk);
        bus_idle();
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge iClk);
        bus_if.iChipSelect_n = 1'b0;
        bus_if.iRead_n       = 1'b0;
        bus_if.iAddress      = a;
        @(negedge iClk);
        d = bus_if.oData;
        bus_idle();
    endtask

    task automatic load_block(input logic [0:15][31:0] blk);
        for (int i = 0; i < 16; i++) wr(8'(i), blk[i]);
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val,
                               output logic [31:0] st, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            rd(8'h11, st);
            if ((st & mask) == val) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        iReset = 1'b1;
        bus_idle();
        repeat (3) @(negedge iClk);
        iReset = 1'b0;
        @(negedge iClk);
        total++;
        if (bus_if.oData !== 32'h0) begin bad++; $display("FAIL reset_odata got=%h exp=0", bus_if.oData); end
        rd(8'h11, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL reset_status got=%h exp=00000004", d); end
        rd(8'h80, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_digest0 got=%h exp=0", d); end
        rd(8'h40, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_unmapped got=%h exp=0", d); end
        rd(8'h05, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_staging got=%h exp=0", d); end
    endtask

    task automatic test_single_block();
        logic [0:15][31:0] blk;
        logic [0:7][31:0]  exp_dg;
        logic [31:0]       d, st;
        bit                ok;
        blk     = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        exp_dg  = {32'hBA7816BF, 32'h8F01CFEA, 32'h414140DE, 32'h5DAE2223,
                   32'hB00361A3, 32'h96177A9C, 32'hB410FF61, 32'hF20015AD};
        load_block(blk);
        wr(8'h10, 32'h3);
        wait_status(32'h2, 32'h2, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL abc_timeout status=%h exp_dv=1", st); end
        for (int i = 0; i < 8; i++) begin
            rd(8'h80 + 8'(i), d);
            total++;
            if (d !== exp_dg[i]) begin bad++; $display("FAIL abc_digest%0d got=%h exp=%h", i, d, exp_dg[i]); end
        end
        rd(8'h11, d);
        total++;
        if (d !== 32'h6) begin bad++; $display("FAIL abc_status got=%h exp=00000006", d); end
        rd(8'h00, d);
        total++;
        if (d !== 32'h61626380) begin bad++; $display("FAIL abc_staging_kept got=%h exp=61626380", d); end
        rd(8'h10, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ctrl_read got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back();
        logic [0:15][31:0] b0, b1;
        logic [0:7][31:0]  exp_dg;
        logic [31:0]       d, st;
        bit                ok;
        b0 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        b1 = '0;
        b1[15] = 32'h000001C0;
        exp_dg = {32'h248D6A61, 32'hD20638B8, 32'hE5C02693, 32'h0C3E6039,
                  32'hA33CE459, 32'h64FF2167, 32'hF6ECEDD4, 32'h19DB06C1};
        load_block(b0);
        wr(8'h10, 32'h2);
        load_block(b1);
        wr(8'h10, 32'h3);
        rd(8'h11, d);
        total++;
        if ((d & 32'h3) !== 32'h1) begin bad++; $display("FAIL b2b_dv_low got=%h exp_busy1_dv0", d & 32'h3); end
        wait_status(32'h2, 32'h2, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_timeout status=%h exp_dv=1", st); end
        for (int i = 0; i < 8; i++) begin
            rd(8'h80 + 8'(i), d);
            total++;
            if (d !== exp_dg[i]) begin bad++; $display("FAIL b2b_digest%0d got=%h exp=%h", i, d, exp_dg[i]); end
        end
        rd(8'h11, d);
        total++;
        if (d !== 32'h6) begin bad++; $display("FAIL b2b_status got=%h exp=00000006", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, st;
        bit          ok;
        wr(8'h10, 32'h2);
        wr(8'h10, 32'h2);
        wr(8'h10, 32'h2);
        rd(8'h11, d);
        total++;
        if (d !== 32'h219) begin bad++; $display("FAIL ovf_status got=%h exp=00000219", d); end
        wait_status(32'h1, 32'h0, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL ovf_timeout status=%h exp_busy=0", st); end
        total++;
        if (st !== 32'h14) begin bad++; $display("FAIL ovf_sticky got=%h exp=00000014", st); end
    endtask

    task automatic test_soft_clear();
        logic [31:0] d;
        wr(8'h10, 32'h2);
        repeat (20) @(negedge iClk);
        wr(8'h10, 32'h4);
        rd(8'h11, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL clr_status got=%h exp=00000004", d); end
        repeat (100) @(negedge iClk);
        rd(8'h11, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL clr_no_capture got=%h exp=00000004", d); end
        rd(8'h80, d);
        total++;
        if (d !== 32'h248D6A61) begin bad++; $display("FAIL clr_digest_kept got=%h exp=248d6a61", d); end
        wr(8'h10, 32'h6);
        rd(8'h11, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL clr_push_dropped got=%h exp=00000004", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        wr(8'h40, 32'hDEADBEEF);
        rd(8'h40, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rw got=%h exp=0", d); end
        rd(8'h88, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unmapped_88 got=%h exp=0", d); end
        wr(8'h11, 32'hFFFFFFFF);
        rd(8'h11, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL status_ro got=%h exp=00000004", d); end
`ifndef SHA256_IRQ_EN
        rd(8'h12, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL irq_unmapped got=%h exp=0", d); end
`endif
    endtask

`ifdef SHA256_IRQ_EN
    task automatic test_irq();
        logic [0:15][31:0] blk;
        logic [31:0]       d, st;
        bit                ok;
        blk     = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        wr(8'h12, 32'h1);
        load_block(blk);
        wr(8'h10, 32'h3);
        total++;
        if (oIrq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", oIrq); end
        wait_status(32'h2, 32'h2, st, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL irq_timeout status=%h exp_dv=1", st); end
        total++;
        if (oIrq !== 1'b1) begin bad++; $display("FAIL irq_high got=%b exp=1", oIrq); end
        rd(8'h12, d);
        total++;
        if (d !== 32'h3) begin bad++; $display("FAIL irq_reg got=%h exp=00000003", d); end
        wr(8'h12, 32'h3);
        @(negedge iClk);
        total++;
        if (oIrq !== 1'b0) begin bad++; $display("FAIL irq_cleared got=%b exp=0", oIrq); end
        rd(8'h12, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL irq_reg_clr got=%h exp=00000001", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_overflow();
        test_soft_clear();
        test_unmapped();
`ifdef SHA256_IRQ_EN
        test_irq();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
